// File: rtl/lzd_pkg.sv
// Shared constants, leaf-result type and width helper for the lzd_pipe leading-zero detector.
package lzd_pkg;

    localparam int LZD_LEAF_W = 4;
    localparam int LZD_STAGES = 2;

    typedef struct packed {
        logic       any;
        logic [1:0] pos;
    } leaf_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lzd_4b.sv
// Nibble leaf detector: flags a nonzero nibble and reports the index of its highest set bit.
module lzd_4b
    import lzd_pkg::*;
(
    input  logic [LZD_LEAF_W-1:0] nib,
    output leaf_t                 res
);

    always_comb begin
        res.any = |nib;
        if (nib[3])      res.pos = 2'd3;
        else if (nib[2]) res.pos = 2'd2;
        else if (nib[1]) res.pos = 2'd1;
        else             res.pos = 2'd0;
    end

endmodule

// File: rtl/lzd_pipe.sv
// Two-stage leading-zero / priority detector with valid/ready handshake and sideband tag.
// Optional normaliser output o_norm is built when LZD_PIPE_NORM_EN is defined.
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
)(
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WIDTH-1:0]        i_a,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [clog2(WIDTH)-1:0] o_po,
    output logic                    o_po_valid,
    output logic [clog2(WIDTH):0]   o_lzc,
    output logic [TAG_W-1:0]        o_tag
`ifdef LZD_PIPE_NORM_EN
    ,
    output logic [WIDTH-1:0]        o_norm
`endif
);

    localparam int NLEAF = WIDTH / LZD_LEAF_W;
    localparam int PO_W  = clog2(WIDTH);
    localparam int LZC_W = PO_W + 1;
    localparam int NL_W  = clog2(NLEAF);

    leaf_t [NLEAF-1:0] leaf_c;
    leaf_t [NLEAF-1:0] leaf_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic              vld_p1;
    logic              vld_p2;
    logic              en1;
    logic              en2;

    logic              any_m;
    logic [PO_W-1:0]   po_m;
    logic [LZC_W-1:0]  lzc_m;

    logic [PO_W-1:0]   po_p2;
    logic              pov_p2;
    logic [LZC_W-1:0]  lzc_p2;
    logic [TAG_W-1:0]  tag_p2;

    // A stage loads when empty or when its contents leave in the same cycle.
    assign en2     = !vld_p2 || i_ready;
    assign en1     = !vld_p1 || en2;
    assign o_ready = i_rstn && en1;

    for (genvar g = 0; g < NLEAF; g++) begin : g_leaf
        lzd_4b u_leaf (
            .nib (i_a[g*LZD_LEAF_W +: LZD_LEAF_W]),
            .res (leaf_c[g])
        );
    end

    // ---- stage 1: per-nibble leaf results ----
    always_ff @(posedge i_clk) begin
        if (!i_rstn)  vld_p1 <= 1'b0;
        else if (en1) vld_p1 <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (en1 && i_valid) begin
            leaf_p1 <= leaf_c;
            tag_p1  <= i_tag;
        end
    end

    // Ascending scan so the most-significant nonzero nibble wins.
    always_comb begin
        any_m = 1'b0;
        po_m  = '0;
        for (int i = 0; i < NLEAF; i++) begin
            if (leaf_p1[i].any) begin
                any_m = 1'b1;
                po_m  = {NL_W'(i), leaf_p1[i].pos};
            end
        end
        lzc_m = any_m ? (LZC_W'(WIDTH - 1) - {1'b0, po_m}) : LZC_W'(WIDTH);
    end

    // ---- stage 2: merged tree result ----
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_p2 <= 1'b0;
            po_p2  <= '0;
            pov_p2 <= 1'b0;
            lzc_p2 <= '0;
            tag_p2 <= '0;
        end else if (en2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                po_p2  <= po_m;
                pov_p2 <= any_m;
                lzc_p2 <= lzc_m;
                tag_p2 <= tag_p1;
            end
        end
    end

    assign o_valid    = vld_p2;
    assign o_po       = po_p2;
    assign o_po_valid = pov_p2;
    assign o_lzc      = lzc_p2;
    assign o_tag      = tag_p2;

`ifdef LZD_PIPE_NORM_EN
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] norm_p2;

    always_ff @(posedge i_clk) begin
        if (en1 && i_valid) a_p1 <= i_a;
    end

    // A zero operand gives lzc=WIDTH, which shifts everything out.
    always_ff @(posedge i_clk) begin
        if (!i_rstn)                 norm_p2 <= '0;
        else if (en2 && vld_p1)      norm_p2 <= a_p1 << lzc_m;
    end

    assign o_norm = norm_p2;
`endif

endmodule

// File: tb/tb_lzd_pipe.sv
// Directed and randomised bench for lzd_pipe at WIDTH=32 (normaliser checks when LZD_PIPE_NORM_EN is defined).
`timescale 1ns/1ps
module tb_lzd_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a;
    logic [3:0]  tag;
    logic        r_valid;
    logic        r_ready;
    logic [4:0]  po;
    logic        po_valid;
    logic [5:0]  lzc;
    logic [3:0]  r_tag;
`ifdef LZD_PIPE_NORM_EN
    logic [31:0] norm;
`endif

    int checks = 0;
    int errors = 0;

    lzd_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (a_valid),
        .o_ready    (a_ready),
        .i_a        (a),
        .i_tag      (tag),
        .o_valid    (r_valid),
        .i_ready    (r_ready),
        .o_po       (po),
        .o_po_valid (po_valid),
        .o_lzc      (lzc),
        .o_tag      (r_tag)
`ifdef LZD_PIPE_NORM_EN
        ,
        .o_norm     (norm)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: scan from the MSB down for the first set bit.
    function automatic void model(input logic [31:0] v, output logic [4:0] m_po,
                                  output logic m_pov, output logic [5:0] m_lzc);
        m_po  = '0;
        m_pov = 1'b0;
        m_lzc = 6'd32;
        for (int b = 31; b >= 0; b--) begin
            if (v[b] && !m_pov) begin
                m_pov = 1'b1;
                m_po  = 5'(b);
                m_lzc = 6'(31 - b);
            end
        end
    endfunction

    task automatic test_reset();
        rstn = 1'b0; a_valid = 1'b0; a = '0; tag = '0; r_ready = 1'b1;
        step();
        step();
        checks++; if (r_valid !== 1'b0)  begin errors++; $display("FAIL reset_o_valid: got %0d expected 0", r_valid); end
        checks++; if (a_ready !== 1'b0)  begin errors++; $display("FAIL reset_o_ready: got %0d expected 0", a_ready); end
        checks++; if (po !== 5'd0)       begin errors++; $display("FAIL reset_o_po: got %0d expected 0", po); end
        checks++; if (po_valid !== 1'b0) begin errors++; $display("FAIL reset_o_po_valid: got %0d expected 0", po_valid); end
        checks++; if (lzc !== 6'd0)      begin errors++; $display("FAIL reset_o_lzc: got %0d expected 0", lzc); end
        checks++; if (r_tag !== 4'd0)    begin errors++; $display("FAIL reset_o_tag: got %0d expected 0", r_tag); end
`ifdef LZD_PIPE_NORM_EN
        checks++; if (norm !== 32'd0)    begin errors++; $display("FAIL reset_o_norm: got %h expected 0", norm); end
`endif
        rstn = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL ready_after_reset: got %0d expected 1", a_ready); end
    endtask

    task automatic test_basic();
        r_ready = 1'b1;
        a_valid = 1'b1; a = 32'h0001_0000; tag = 4'd3;
        step();
        a_valid = 1'b0;
        checks++; if (r_valid !== 1'b0)  begin errors++; $display("FAIL basic_latency1: o_valid got %0d expected 0", r_valid); end
        step();
        checks++; if (r_valid !== 1'b1)  begin errors++; $display("FAIL basic_latency2: o_valid got %0d expected 1", r_valid); end
        checks++; if (po !== 5'd16)      begin errors++; $display("FAIL basic_po: got %0d expected 16", po); end
        checks++; if (lzc !== 6'd15)     begin errors++; $display("FAIL basic_lzc: got %0d expected 15", lzc); end
        checks++; if (po_valid !== 1'b1) begin errors++; $display("FAIL basic_po_valid: got %0d expected 1", po_valid); end
        checks++; if (r_tag !== 4'd3)    begin errors++; $display("FAIL basic_tag: got %0d expected 3", r_tag); end
        step();
    endtask

    task automatic test_boundaries();
        logic [31:0] vec   [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                   32'h0000_F000, 32'h0000_0010, 32'h7FFF_FFFF};
        logic [4:0]  e_po  [6] = '{5'd0, 5'd31, 5'd0, 5'd15, 5'd4, 5'd30};
        logic [5:0]  e_lzc [6] = '{6'd32, 6'd0, 6'd31, 6'd16, 6'd27, 6'd1};
        logic        e_pov [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int n;
        r_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; a = vec[k]; tag = 4'(k + 8);
            step();
            a_valid = 1'b0;
            n = 0;
            while (!r_valid && n < 10) begin step(); n++; end
            checks++;
            if (r_valid !== 1'b1) begin
                errors++; $display("FAIL bound_timeout[%0d]: o_valid got %0d expected 1", k, r_valid);
            end else begin
                if (po_valid !== e_pov[k]) begin errors++; $display("FAIL bound_po_valid[%0d]: got %0d expected %0d", k, po_valid, e_pov[k]); end
                checks++; if (po !== e_po[k])           begin errors++; $display("FAIL bound_po[%0d]: got %0d expected %0d", k, po, e_po[k]); end
                checks++; if (lzc !== e_lzc[k])         begin errors++; $display("FAIL bound_lzc[%0d]: got %0d expected %0d", k, lzc, e_lzc[k]); end
                checks++; if (r_tag !== 4'(k + 8))      begin errors++; $display("FAIL bound_tag[%0d]: got %0d expected %0d", k, r_tag, k + 8); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec   [8] = '{32'h0000_0001, 32'h0000_0100, 32'h0080_0000, 32'h4000_0000,
                                   32'h0000_0000, 32'h0000_FFFF, 32'h1234_5678, 32'h0000_0C00};
        logic [4:0]  e_po  [8] = '{5'd0, 5'd8, 5'd23, 5'd30, 5'd0, 5'd15, 5'd28, 5'd11};
        logic [5:0]  e_lzc [8] = '{6'd31, 6'd23, 6'd8, 6'd1, 6'd32, 6'd16, 6'd3, 6'd20};
        logic        e_pov [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] saved;
        logic        held;
        int idx, rx, cyc, extra;
        idx = 0; rx = 0; cyc = 0; held = 1'b0; saved = '0;
        while (rx < 8 && cyc < 60) begin
            a_valid = (idx < 8);
            a       = (idx < 8) ? vec[idx] : 32'd0;
            tag     = 4'(idx);
            r_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (held) begin
                checks++;
                if (!r_valid || {po_valid, po, lzc, r_tag} !== saved) begin
                    errors++; $display("FAIL b2b_hold: got %h expected %h", {po_valid, po, lzc, r_tag}, saved);
                end
            end
            if (cyc == 3) begin
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_stall: got %0d expected 0", a_ready); end
            end
            if (cyc == 7) begin
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_resume: got %0d expected 1", a_ready); end
            end
            held  = r_valid && !r_ready;
            saved = {po_valid, po, lzc, r_tag};
            if (r_valid && r_ready) begin
                checks++;
                if (rx >= 8) begin
                    errors++; $display("FAIL b2b_extra: got result %0d expected none", rx);
                end else if ({po_valid, po, lzc, r_tag} !== {e_pov[rx], e_po[rx], e_lzc[rx], 4'(rx)}) begin
                    errors++; $display("FAIL b2b_result[%0d]: got pov=%0d po=%0d lzc=%0d tag=%0d expected pov=%0d po=%0d lzc=%0d tag=%0d",
                                       rx, po_valid, po, lzc, r_tag, e_pov[rx], e_po[rx], e_lzc[rx], rx);
                end
                rx++;
            end
            if (a_valid && a_ready) idx++;
            step();
            cyc++;
        end
        a_valid = 1'b0;
        r_ready = 1'b1;
        checks++; if (rx != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", rx); end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (r_valid) extra++;
            step();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        r_ready = 1'b0;
        a_valid = 1'b1; a = 32'h00FF_0000; tag = 4'd5;
        step();
        a = 32'h0000_0001; tag = 4'd6;
        step();
        a_valid = 1'b0;
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: o_valid got %0d expected 1", r_valid); end
        rstn = 1'b0;
        step();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0d expected 0", r_valid); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %0d expected 0", a_ready); end
        checks++; if (po !== 5'd0)      begin errors++; $display("FAIL midrst_po: got %0d expected 0", po); end
        rstn = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_high: got %0d expected 1", a_ready); end
        r_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (r_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale: got %0d results expected 0", seen); end
    endtask

`ifdef LZD_PIPE_NORM_EN
    task automatic test_norm();
        int n;
        r_ready = 1'b1;
        a_valid = 1'b1; a = 32'h0000_3A00; tag = 4'd1;
        step();
        a_valid = 1'b0;
        n = 0;
        while (!r_valid && n < 10) begin step(); n++; end
        checks++; if (lzc !== 6'd18)         begin errors++; $display("FAIL norm_lzc: got %0d expected 18", lzc); end
        checks++; if (norm !== 32'hE800_0000) begin errors++; $display("FAIL norm_value: got %h expected e8000000", norm); end
        step();
    endtask
`endif

    task automatic test_random();
        logic [31:0] qa [$];
        logic [3:0]  qt [$];
        logic [31:0] ea;
        logic [3:0]  et;
        logic [4:0]  m_po;
        logic        m_pov;
        logic [5:0]  m_lzc;
        logic        held;
        logic [15:0] saved;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held = 1'b0; saved = '0;
        while ((sent < 3000 || got < sent) && cyc < 40000) begin
            a_valid = (sent < 3000) && ($urandom_range(0, 3) != 0);
            a       = $urandom >> $urandom_range(0, 32);
            tag     = 4'($urandom);
            r_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held) begin
                checks++;
                if (!r_valid || {po_valid, po, lzc, r_tag} !== saved) begin
                    errors++; $display("FAIL rand_hold: got %h expected %h", {po_valid, po, lzc, r_tag}, saved);
                end
            end
            held  = r_valid && !r_ready;
            saved = {po_valid, po, lzc, r_tag};
            if (r_valid && r_ready) begin
                checks++;
                got++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got result with tag %0d expected none", r_tag);
                end else begin
                    ea = qa.pop_front();
                    et = qt.pop_front();
                    model(ea, m_po, m_pov, m_lzc);
                    if ({po_valid, po, lzc, r_tag} !== {m_pov, m_po, m_lzc, et}) begin
                        errors++; $display("FAIL rand_result a=%h: got pov=%0d po=%0d lzc=%0d tag=%0d expected pov=%0d po=%0d lzc=%0d tag=%0d",
                                           ea, po_valid, po, lzc, r_tag, m_pov, m_po, m_lzc, et);
                    end
`ifdef LZD_PIPE_NORM_EN
                    checks++;
                    if (norm !== (ea << m_lzc)) begin
                        errors++; $display("FAIL rand_norm a=%h: got %h expected %h", ea, norm, ea << m_lzc);
                    end
`endif
                end
            end
            if (a_valid && a_ready) begin
                qa.push_back(a);
                qt.push_back(tag);
                sent++;
            end
            step();
            cyc++;
        end
        a_valid = 1'b0;
        checks++; if (got != 3000 || sent != 3000) begin errors++; $display("FAIL rand_count: got %0d of %0d sent expected 3000", got, sent); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_midflight();
`ifdef LZD_PIPE_NORM_EN
        test_norm();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
